// File: rtl/cache_mem_bridge_pkg.sv
// Shared word/line types, beat sizing and FSM state encoding for the cache memory bridge.
package cache_mem_bridge_pkg;

    localparam int unsigned WORD_W     = 32;
    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned LINE_W     = WORD_W * LINE_WORDS;
    localparam int unsigned BEAT_W     = $clog2(LINE_WORDS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef logic [WORD_W-1:0] word_t;
    // Word 0 of a line occupies bits [31:0].
    typedef logic [LINE_WORDS-1:0][WORD_W-1:0] line_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BEAT,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic  wr;
        word_t base;
        line_t wline;
    } req_t;

    function automatic word_t beat_addr(input word_t base, input logic [BEAT_W-1:0] beat);
        return base + WORD_W'({beat, 2'b00});
    endfunction

endpackage

// File: rtl/cache_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr_i.
module cache_rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]                            req_i,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0]    ptr_i,
    output logic [N-1:0]                            grant_o,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]    idx_o,
    output logic                                    any_o
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    always_comb begin
        int unsigned cand;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand    = 0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = (32'(ptr_i) + i) % N;
            if (!any_o && req_i[IW'(cand)]) begin
                any_o                = 1'b1;
                idx_o                = IW'(cand);
                grant_o[IW'(cand)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_mem_bridge.sv
// Arbitrates line requests from the cache controllers and serializes each into
// four word beats on the memory master, returning the line or a write acknowledge.
module cache_mem_bridge
    import cache_mem_bridge_pkg::*;
#(
    parameter int unsigned CACHES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          cache_address [CACHES],
    input  logic [CACHES-1:0]    cache_read,
    input  logic [CACHES-1:0]    cache_write,
    input  logic [127:0]         cache_writedata [CACHES],
    output logic [127:0]         cache_readdata [CACHES],
    output logic [CACHES-1:0]    cache_waitrequest,
    output logic [31:0]          mem_address,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [31:0]          mem_writedata,
    input  logic [31:0]          mem_readdata,
    input  logic                 mem_waitrequest
);

    localparam int unsigned IW = (CACHES > 1) ? $clog2(CACHES) : 1;

    state_e              state_q, state_d;
    logic [IW-1:0]       port_q, port_d;
    logic [IW-1:0]       rr_ptr_q, rr_ptr_d;
    req_t                req_q, req_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    line_t               rbuf_q, rbuf_d;
    word_t               mem_address_q, mem_address_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    word_t               mem_writedata_q, mem_writedata_d;

    logic [CACHES-1:0]   req_vec;
    logic [CACHES-1:0]   gnt;
    logic [IW-1:0]       gnt_idx;
    logic                gnt_any;

    assign req_vec = cache_read | cache_write;

    cache_rr_arbiter #(
        .N (CACHES)
    ) u_arb (
        .req_i   (req_vec),
        .ptr_i   (rr_ptr_q),
        .grant_o (gnt),
        .idx_o   (gnt_idx),
        .any_o   (gnt_any)
    );

    // Next-state and next-output logic; the memory master outputs are computed one beat ahead.
    always_comb begin
        state_d         = state_q;
        port_d          = port_q;
        rr_ptr_d        = rr_ptr_q;
        req_d           = req_q;
        beat_d          = beat_q;
        rbuf_d          = rbuf_q;
        mem_address_d   = mem_address_q;
        mem_read_d      = mem_read_q;
        mem_write_d     = mem_write_q;
        mem_writedata_d = mem_writedata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    // A port raising both read and write is served as a write.
                    port_d          = gnt_idx;
                    req_d.wr        = |(gnt & cache_write);
                    req_d.base      = cache_address[gnt_idx];
                    req_d.wline     = cache_writedata[gnt_idx];
                    beat_d          = '0;
                    mem_address_d   = cache_address[gnt_idx];
                    mem_read_d      = !(|(gnt & cache_write));
                    mem_write_d     = |(gnt & cache_write);
                    mem_writedata_d = cache_writedata[gnt_idx][WORD_W-1:0];
                    state_d         = ST_BEAT;
                end
            end
            ST_BEAT: begin
                if (!mem_waitrequest) begin
                    if (!req_q.wr) begin
                        rbuf_d[beat_q] = mem_readdata;
                    end
                    if (beat_q == LAST_BEAT) begin
                        mem_read_d  = 1'b0;
                        mem_write_d = 1'b0;
                        state_d     = ST_DONE;
                    end else begin
                        beat_d          = beat_q + BEAT_W'(1);
                        mem_address_d   = beat_addr(req_q.base, beat_d);
                        mem_writedata_d = req_q.wline[beat_d];
                    end
                end
            end
            ST_DONE: begin
                rr_ptr_d = (port_q == IW'(CACHES - 1)) ? '0 : port_q + IW'(1);
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            port_q          <= '0;
            rr_ptr_q        <= '0;
            req_q           <= '0;
            beat_q          <= '0;
            rbuf_q          <= '0;
            mem_address_q   <= '0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_writedata_q <= '0;
        end else begin
            state_q         <= state_d;
            port_q          <= port_d;
            rr_ptr_q        <= rr_ptr_d;
            req_q           <= req_d;
            beat_q          <= beat_d;
            rbuf_q          <= rbuf_d;
            mem_address_q   <= mem_address_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_writedata_q <= mem_writedata_d;
        end
    end

    assign mem_address   = mem_address_q;
    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_writedata = mem_writedata_q;

    // Acknowledge is a pure decode of registered state, so no input reaches it combinationally.
    for (genvar g = 0; g < CACHES; g++) begin : g_port
        assign cache_waitrequest[g] = !((state_q == ST_DONE) && (port_q == IW'(g)));
        assign cache_readdata[g]    = rbuf_q;
    end

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Directed bench for cache_mem_bridge with a small word memory and stall injector.
module tb_cache_mem_bridge;

    localparam int unsigned CACHES = 4;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } beat_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [31:0]         cache_address [CACHES];
    logic [CACHES-1:0]   cache_read;
    logic [CACHES-1:0]   cache_write;
    logic [127:0]        cache_writedata [CACHES];
    logic [127:0]        cache_readdata [CACHES];
    logic [CACHES-1:0]   cache_waitrequest;
    logic [31:0]         mem_address;
    logic                mem_read;
    logic                mem_write;
    logic [31:0]         mem_writedata;
    logic [31:0]         mem_readdata;
    logic                mem_waitrequest;

    cache_mem_bridge #(.CACHES(CACHES)) dut (
        .clk               (clk),
        .rst               (rst),
        .cache_address     (cache_address),
        .cache_read        (cache_read),
        .cache_write       (cache_write),
        .cache_writedata   (cache_writedata),
        .cache_readdata    (cache_readdata),
        .cache_waitrequest (cache_waitrequest),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_writedata     (mem_writedata),
        .mem_readdata      (mem_readdata),
        .mem_waitrequest   (mem_waitrequest)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Memory model: answers reads from a word store, logs completed beats, injects stalls.
    logic [31:0] memory [logic [31:0]];
    beat_t       beats [$];
    logic [63:0] stall_samples [$];
    int          stall_cnt  = 0;
    logic [31:0] stall_addr = 32'h0;
    logic        saw_read   = 1'b0;

    initial begin
        mem_waitrequest = 1'b0;
        mem_readdata    = 32'h0;
        forever begin
            @(negedge clk);
            mem_waitrequest = 1'b0;
            if (mem_read || mem_write) begin
                if (mem_read) saw_read = 1'b1;
                mem_readdata = memory.exists(mem_address) ? memory[mem_address] : 32'h0;
                if (stall_cnt > 0 && mem_address == stall_addr) begin
                    mem_waitrequest = 1'b1;
                    stall_cnt--;
                    stall_samples.push_back({mem_address, mem_writedata});
                end else begin
                    beats.push_back('{rd: mem_read, wr: mem_write, addr: mem_address, data: mem_writedata});
                end
            end
        end
    end

    task automatic wait_ack(input int port, input int budget, output int cycles, output logic ok);
        cycles = 1;
        ok     = 1'b0;
        for (int k = 0; k < budget && !ok; k++) begin
            @(negedge clk);
            cycles++;
            if (!cache_waitrequest[port]) ok = 1'b1;
        end
    endtask

    task automatic check_write_beats(input string tag, input logic [31:0] base, input logic [127:0] line);
        logic [127:0] l;
        l = line;
        check_eq({tag, "_nbeats"}, 128'(beats.size()), 128'd4);
        for (int k = 0; k < 4 && k < beats.size(); k++) begin
            check_eq($sformatf("%s_addr%0d", tag, k), 128'(beats[k].addr), 128'(base + 32'(4 * k)));
            check_eq($sformatf("%s_data%0d", tag, k), 128'(beats[k].data), 128'(l[32*k +: 32]));
            check_eq($sformatf("%s_op%0d", tag, k), 128'({beats[k].rd, beats[k].wr}), 128'(2'b01));
        end
    endtask

    initial begin
        int     cyc;
        logic   ok;
        int     order [$];
        int     exp_order [5];
        logic   rereq;
        int     acks;
        int     rd_seen;
        logic [127:0] wl;

        exp_order = '{0, 1, 2, 3, 0};
        rst         = 1'b1;
        cache_read  = '0;
        cache_write = '0;
        for (int p = 0; p < CACHES; p++) begin
            cache_address[p]   = 32'h0;
            cache_writedata[p] = 128'h0;
        end
        memory[32'h1230] = 32'h11111111;
        memory[32'h1234] = 32'h22222222;
        memory[32'h1238] = 32'h33333333;
        memory[32'h123C] = 32'h44444444;
        for (int p = 1; p <= 5; p++)
            for (int k = 0; k < 4; k++)
                memory[32'(p * 32'h100 + 4 * k)] = 32'(p << 24) | 32'(k);

        // Reset values
        repeat (2) @(negedge clk);
        check_eq("rst_mem_read", 128'(mem_read), 128'd0);
        check_eq("rst_mem_write", 128'(mem_write), 128'd0);
        check_eq("rst_mem_address", 128'(mem_address), 128'd0);
        check_eq("rst_mem_writedata", 128'(mem_writedata), 128'd0);
        check_eq("rst_waitrequest", 128'(cache_waitrequest), 128'hF);
        check_eq("rst_readdata", cache_readdata[0], 128'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single read on port 1
        beats.delete();
        saw_read = 1'b0;
        cache_address[1] = 32'h00001230;
        cache_read[1]    = 1'b1;
        wait_ack(1, 20, cyc, ok);
        check_eq("rd_ack_seen", 128'(ok), 128'd1);
        check_eq("rd_latency", 128'(cyc), 128'd6);
        check_eq("rd_line", cache_readdata[1], 128'h44444444_33333333_22222222_11111111);
        check_eq("rd_ack_onehot", 128'(cache_waitrequest), 128'b1101);
        cache_read[1] = 1'b0;
        check_eq("rd_nbeats", 128'(beats.size()), 128'd4);
        for (int k = 0; k < 4 && k < beats.size(); k++) begin
            check_eq($sformatf("rd_addr%0d", k), 128'(beats[k].addr), 128'(32'h1230 + 32'(4 * k)));
            check_eq($sformatf("rd_op%0d", k), 128'({beats[k].rd, beats[k].wr}), 128'(2'b10));
        end

        // Single write on port 0
        @(negedge clk);
        beats.delete();
        saw_read = 1'b0;
        wl = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
        cache_address[0]   = 32'h00000040;
        cache_writedata[0] = wl;
        cache_write[0]     = 1'b1;
        wait_ack(0, 20, cyc, ok);
        check_eq("wr_ack_seen", 128'(ok), 128'd1);
        check_eq("wr_latency", 128'(cyc), 128'd6);
        cache_write[0] = 1'b0;
        @(negedge clk);
        check_eq("wr_ack_one_cycle", 128'(cache_waitrequest), 128'hF);
        check_eq("wr_no_read", 128'(saw_read), 128'd0);
        check_write_beats("wr", 32'h40, wl);

        // Stall of three cycles on beat 2 of a write from port 3
        beats.delete();
        stall_samples.delete();
        stall_addr = 32'h88;
        stall_cnt  = 3;
        wl = 128'h0F0F0F0F_98765432_13579BDF_01234567;
        cache_address[3]   = 32'h00000080;
        cache_writedata[3] = wl;
        cache_write[3]     = 1'b1;
        wait_ack(3, 30, cyc, ok);
        check_eq("st_ack_seen", 128'(ok), 128'd1);
        check_eq("st_latency", 128'(cyc), 128'd9);
        cache_write[3] = 1'b0;
        check_eq("st_nsamples", 128'(stall_samples.size()), 128'd3);
        foreach (stall_samples[i])
            check_eq($sformatf("st_hold%0d", i), 128'(stall_samples[i]), 128'({32'h88, 32'h98765432}));
        check_write_beats("st", 32'h80, wl);

        // Read and write together on port 2 is a write
        @(negedge clk);
        beats.delete();
        saw_read = 1'b0;
        wl = 128'h44440004_33330003_22220002_11110001;
        cache_address[2]   = 32'h00000600;
        cache_writedata[2] = wl;
        cache_read[2]      = 1'b1;
        cache_write[2]     = 1'b1;
        wait_ack(2, 20, cyc, ok);
        check_eq("cf_ack_seen", 128'(ok), 128'd1);
        cache_read[2]  = 1'b0;
        cache_write[2] = 1'b0;
        check_eq("cf_no_read", 128'(saw_read), 128'd0);
        check_write_beats("cf", 32'h600, wl);

        // Contention from reset: all four ports read at once
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int p = 0; p < CACHES; p++) cache_address[p] = 32'((p + 1) * 32'h100);
        cache_read = 4'hF;
        rereq = 1'b0;
        for (int k = 0; k < 120 && order.size() < 5; k++) begin
            @(negedge clk);
            for (int p = 0; p < CACHES; p++) begin
                if (!cache_waitrequest[p]) begin
                    order.push_back(p);
                    if (p == 2)
                        check_eq("ct_line_p2", cache_readdata[2], 128'h03000003_03000002_03000001_03000000);
                    cache_read[p] = 1'b0;
                    if (p == 0 && !rereq) begin
                        rereq            = 1'b1;
                        cache_address[0] = 32'h500;
                        cache_read[0]    = 1'b1;
                    end
                end
            end
        end
        check_eq("ct_nacks", 128'(order.size()), 128'd5);
        for (int i = 0; i < 5 && i < order.size(); i++)
            check_eq($sformatf("ct_order%0d", i), 128'(order[i]), 128'(exp_order[i]));

        // Reset during beat 1 of a read on port 1
        @(negedge clk);
        cache_address[1] = 32'h00000700;
        cache_read[1]    = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (mem_read && mem_address == 32'h704) ok = 1'b1;
        end
        check_eq("rs_reached_beat1", 128'(ok), 128'd1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rs_mem_read", 128'(mem_read), 128'd0);
        check_eq("rs_mem_address", 128'(mem_address), 128'd0);
        check_eq("rs_waitrequest", 128'(cache_waitrequest), 128'hF);
        rst           = 1'b0;
        cache_read[1] = 1'b0;
        acks    = 0;
        rd_seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (cache_waitrequest != 4'hF) acks++;
            if (mem_read) rd_seen++;
        end
        check_eq("rs_no_ack", 128'(acks), 128'd0);
        check_eq("rs_idle_mem", 128'(rd_seen), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_mem_bridge.md
# cache_mem_bridge

Memory-side responder for the cache controllers' line-wide memory port. It accepts whole-line read and write requests from `CACHES` cache controllers and arbitrates between them round-robin. Each granted request is serialized into four 32-bit beats on a word-wide Avalon-style master toward the SDRAM/interconnect. The bridge returns the assembled line to the requesting controller, or acknowledges its writeback. It sits between the per-core `cache_control` instances and the system memory interconnect.

## Interface
- `CACHES`, default 4: number of cache controller ports; must be ≥1.
- Reset is synchronous, active-high; one clock.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `cache_address[CACHES]`  in  32 (`word`)  line byte address; bits [3:0] are always 0.
- `cache_read[CACHES]`  in  1  line read request; held until acknowledged.
- `cache_write[CACHES]`  in  1  line write request; held until acknowledged.
- `cache_writedata[CACHES]`  in  128 (`line`)  line to write.
- `cache_readdata[CACHES]`  out  128  line read result; valid only in the acknowledge cycle.
- `cache_waitrequest[CACHES]`  out  1  low for exactly one cycle to acknowledge a request.
- `mem_address`  out  32  beat byte address.
- `mem_read`  out  1  beat read.
- `mem_write`  out  1  beat write.
- `mem_writedata`  out  32  beat write data.
- `mem_readdata`  in  32  read data; valid in the cycle `mem_read && !mem_waitrequest`.
- `mem_waitrequest`  in  1  downstream stall.

## Operation
- States: IDLE, BEAT, DONE.
- IDLE:
  - Any port with `cache_read|cache_write` is a candidate.
  - The round-robin arbiter grants the first candidate at or after `rr_ptr`.
  - On a grant, latch the port, the op, the address and the write line; set `beat=0`; go to BEAT.
  - If `cache_read` and `cache_write` are both high on one port, that port's request is treated as a write.
- BEAT:
  - Drive `mem_address = base + 4*beat`; drive `mem_read` or `mem_write` per the latched op.
  - `mem_writedata = wline[32*beat +: 32]`. Word 0 is line bits [31:0].
  - A beat completes when `!mem_waitrequest`. On a read, store `mem_readdata` into `rbuf[32*beat +: 32]`.
  - After beat 3 completes, go to DONE. Otherwise increment `beat`; the 2-bit counter never wraps inside a transaction.
- DONE:
  - Drive `cache_waitrequest[port]=0` and `cache_readdata[port]=rbuf`. All other ports stay 1.
  - Set `rr_ptr = port+1` mod `CACHES`; go to IDLE.
- `cache_readdata` is driven as `rbuf` on all ports; consumers sample it only on acknowledge.
- A request withdrawn before acknowledge is a protocol violation. The bridge still finishes all four beats and issues the DONE pulse, which the withdrawn port ignores.
- Requests arriving while busy wait with `cache_waitrequest=1` and no side effects.

## Timing
- Reset values:
  - State IDLE, `rr_ptr=0`.
  - `mem_read=mem_write=0`, `mem_address=0`, `mem_writedata=0`.
  - All `cache_waitrequest=1`, `rbuf=0`.
- Reset mid-transaction aborts the downstream beat at the same edge. The downstream interconnect shares `rst`.
- Grant cycle t (IDLE): no memory activity.
- With zero downstream wait states, beats run on t+1..t+4, DONE on t+5, and the next IDLE grant can happen on t+6.
- Minimum latency from request to acknowledge is 6 cycles; each downstream wait cycle adds one.
- `mem_*` outputs are registered: stable while `mem_waitrequest=1`, and changing only after the edge at which a beat completes.
- `cache_waitrequest` is decoded from the registered state and latched port, so it has no combinational path from any input.

## Structure
- `cache/defs.sv` holds the `word` (32b) and `line` (128b) typedefs and a `LINE_WORDS=4` constant; the bridge reuses them.
- Sub-module `cache_rr_arbiter` (parameter `N`):
  - Inputs: request vector, `rr_ptr`.
  - Outputs: one-hot grant, encoded index, any-request flag.
  - Combinational.
- The FSM, beat counter, line buffers and output registers stay in `cache_mem_bridge`.

## Test plan
- **Single read.** Port 1 reads address 0x00001230; memory returns 0x11111111, 0x22222222, 0x33333333, 0x44444444 with no waits.
  - Beat addresses are 0x1230, 0x1234, 0x1238, 0x123C.
  - Acknowledge comes 6 cycles after the request with `cache_readdata = 0x44444444_33333333_22222222_11111111`.
- **Single write.** Port 0 writes line 0xDDDD…AAAA to 0x00000040.
  - Four `mem_write` beats carry words 0..3 in order at 0x40..0x4C.
  - One-cycle acknowledge; `mem_read` never asserted.
- **Stall.** `mem_waitrequest` is held high 3 cycles on beat 2.
  - `mem_address` stays at base+8 and `mem_writedata` stays stable throughout.
  - Acknowledge comes at 9 cycles.
- **Contention.** All 4 ports request at once, from reset.
  - Service order is 0,1,2,3.
  - Port 0 re-requests immediately and is served after 3, not before 1.
- **Conflict/reset.**
  - Port 2 asserts read and write together: the bridge performs 4 write beats.
  - `rst` asserted at beat 1 of a read: the next cycle is IDLE with `mem_read=0`, all `cache_waitrequest=1` and no acknowledge.
